// File: rtl/oopslogger_pkg.sv
// Shared definitions for the oopslogger SRAM path: bus width defaults and
// sequencer state encodings.
package oopslogger_pkg;

  localparam int unsigned SramAddrW = 17;
  localparam int unsigned SramDataW = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StHold   = 2'd3
  } seq_state_e;

  typedef enum logic {
    OwnLog = 1'b0,
    OwnSpi = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_seq.sv
// SRAM access timing sequencer: IDLE -> SETUP -> STROBE x N -> HOLD -> IDLE,
// producing the chip strobes, tristate enable, read-capture and done pulses.
module sram_seq
  import oopslogger_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic we_i,
  output logic cen_o,
  output logic oen_o,
  output logic wen_o,
  output logic dq_oe_o,
  output logic busy_o,
  output logic capture_o,
  output logic done_o
);

  localparam logic [3:0] CntLoad = 4'(STROBE_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cen_o     = 1'b1;
    oen_o     = 1'b1;
    wen_o     = 1'b1;
    dq_oe_o   = 1'b0;
    busy_o    = 1'b1;
    capture_o = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        if (start_i) state_d = StSetup;
      end
      StSetup: begin
        cen_o   = 1'b0;
        dq_oe_o = we_i;
        cnt_d   = CntLoad;
        state_d = StStrobe;
      end
      StStrobe: begin
        // Reads never drive the bus, so oen low and dq_oe high are exclusive.
        cen_o   = 1'b0;
        dq_oe_o = we_i;
        wen_o   = ~we_i;
        oen_o   = we_i;
        if (cnt_q == 4'd0) begin
          capture_o = ~we_i;
          state_d   = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        cen_o   = 1'b0;
        dq_oe_o = we_i;
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: fair logger/SPI grant in idle, latches the
// winning request and drives it through the sram_seq timing sequencer.
module sram_arbiter
  import oopslogger_pkg::*;
#(
  parameter int unsigned ADDR_W        = SramAddrW,
  parameter int unsigned DATA_W        = SramDataW,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              log_req,
  input  logic [ADDR_W-1:0] log_addr,
  input  logic [DATA_W-1:0] log_wdata,
  output logic              log_done,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_done,
  output logic              sram_cen,
  output logic              sram_oen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              busy
);

  owner_e            last_q, last_d;
  owner_e            own_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              grant;
  logic              seq_busy;
  logic              seq_capture;
  logic              seq_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= OwnSpi;
      own_q   <= OwnLog;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      last_q  <= last_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    grant   = 1'b0;
    last_d  = last_q;
    own_d   = own_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    if (!seq_busy && (log_req || spi_req)) begin
      grant = 1'b1;
      // On a tie the requester that did not win last time goes first.
      if (log_req && (!spi_req || last_q == OwnSpi)) begin
        own_d   = OwnLog;
        addr_d  = log_addr;
        wdata_d = log_wdata;
        we_d    = 1'b1;
      end else begin
        own_d   = OwnSpi;
        addr_d  = spi_addr;
        wdata_d = spi_wdata;
        we_d    = spi_we;
      end
      last_d = own_d;
    end
    rdata_d = seq_capture ? sram_dq_i : rdata_q;
  end

  sram_seq #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start_i  (grant),
    .we_i     (we_q),
    .cen_o    (sram_cen),
    .oen_o    (sram_oen),
    .wen_o    (sram_wen),
    .dq_oe_o  (sram_dq_oe),
    .busy_o   (seq_busy),
    .capture_o(seq_capture),
    .done_o   (seq_done)
  );

  assign busy      = seq_busy;
  assign sram_addr = addr_q;
  assign sram_dq_o = wdata_q;
  assign spi_rdata = rdata_q;
  assign log_done  = seq_done && (own_q == OwnLog);
  assign spi_done  = seq_done && (own_q == OwnSpi);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed access checks plus randomized rounds scored
// against a transaction-level model of grants, latencies and memory contents.
module tb_sram_arbiter;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned S1 = 1;
  localparam int unsigned MemDepth = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          log_req, log_done, spi_req, spi_we, spi_done, busy;
  logic [AW-1:0] log_addr, spi_addr, sram_addr;
  logic [DW-1:0] log_wdata, spi_wdata, spi_rdata, sram_dq_o, sram_dq_i;
  logic          sram_cen, sram_oen, sram_wen, sram_dq_oe;

  logic          log_req1, log_done1, spi_req1, spi_we1, spi_done1, busy1;
  logic [AW-1:0] log_addr1, spi_addr1, sram_addr1;
  logic [DW-1:0] log_wdata1, spi_wdata1, spi_rdata1, sram_dq_o1, sram_dq_i1;
  logic          sram_cen1, sram_oen1, sram_wen1, sram_dq_oe1;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .log_req(log_req), .log_addr(log_addr), .log_wdata(log_wdata), .log_done(log_done),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_done(spi_done),
    .sram_cen(sram_cen), .sram_oen(sram_oen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S1)) dut1 (
    .clk(clk), .rst(rst),
    .log_req(log_req1), .log_addr(log_addr1), .log_wdata(log_wdata1), .log_done(log_done1),
    .spi_req(spi_req1), .spi_we(spi_we1), .spi_addr(spi_addr1), .spi_wdata(spi_wdata1),
    .spi_rdata(spi_rdata1), .spi_done(spi_done1),
    .sram_cen(sram_cen1), .sram_oen(sram_oen1), .sram_wen(sram_wen1), .sram_addr(sram_addr1),
    .sram_dq_o(sram_dq_o1), .sram_dq_oe(sram_dq_oe1), .sram_dq_i(sram_dq_i1), .busy(busy1)
  );

  // SRAM pin model; never-written cells read back a fixed address-derived pattern.
  logic [DW-1:0] mem [MemDepth];
  bit            written [MemDepth];
  always @(negedge clk) begin
    if (!sram_cen && !sram_wen) begin
      mem[sram_addr]     <= sram_dq_o;
      written[sram_addr] <= 1'b1;
    end
  end
  assign sram_dq_i  = written[sram_addr] ? mem[sram_addr] : (sram_addr[7:0] ^ 8'hD3);
  assign sram_dq_i1 = '0;

  // Reference model state.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int last_g;  // 0 = logger served last, 1 = SPI served last
  int vecs = 0;
  int errs = 0;
  int cen_lo, wen_lo, oen_lo, oe_hi;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[7:0] ^ 8'hD3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("inv_oen_wen", 32'(sram_oen | sram_wen), 32'd1);
    check("inv_oe_oen", 32'(sram_dq_oe & ~sram_oen), 32'd0);
    check("inv1_oen_wen", 32'(sram_oen1 | sram_wen1), 32'd1);
    check("inv1_oe_oen", 32'(sram_dq_oe1 & ~sram_oen1), 32'd0);
    check("dut1_log_done", 32'(log_done1), 32'd0);
  endtask

  // One round: each selected requester asks once and drops req on its done pulse.
  task automatic run_round(input bit lr, input bit sr, input bit swe,
                           input logic [AW-1:0] la, input logic [DW-1:0] ld,
                           input logic [AW-1:0] sa, input logic [DW-1:0] sd);
    int q[$];
    int due, n, n_wr, n_rd;
    logic [DW-1:0] rd_before;
    rd_before = spi_rdata;
    if (lr && sr) begin
      if (last_g == 1) begin q.push_back(0); q.push_back(1); end
      else begin q.push_back(1); q.push_back(0); end
    end else if (lr) q.push_back(0);
    else q.push_back(1);
    n    = int'(lr) + int'(sr);
    n_wr = int'(lr) + int'(sr && swe);
    n_rd = int'(sr && !swe);
    cen_lo = 0; wen_lo = 0; oen_lo = 0; oe_hi = 0;
    log_req = lr; log_addr = la; log_wdata = ld;
    spi_req = sr; spi_we = swe; spi_addr = sa; spi_wdata = sd;
    due = 2 + S;
    for (int t = 1; t <= 30 && q.size() > 0; t++) begin
      tick();
      if (t == 1) begin
        // Inputs of the granted requester change after grant and must be ignored.
        if (q[0] == 0) begin log_addr = AW'($urandom); log_wdata = DW'($urandom); end
        else begin spi_addr = AW'($urandom); spi_wdata = DW'($urandom); spi_we = ~spi_we; end
      end
      if (!sram_cen) cen_lo++;
      if (!sram_wen) wen_lo++;
      if (!sram_oen) oen_lo++;
      if (sram_dq_oe) oe_hi++;
      if (!sram_wen) begin
        check("wr_addr", 32'(sram_addr), 32'((q[0] == 0) ? la : sa));
        check("wr_data", 32'(sram_dq_o), 32'((q[0] == 0) ? ld : sd));
      end
      if (!sram_oen) check("rd_addr", 32'(sram_addr), 32'(sa));
      if (log_done || spi_done) begin
        check("done_owner", 32'({log_done, spi_done}), (q[0] == 0) ? 32'd2 : 32'd1);
        check("done_latency", 32'(t), 32'(due));
        if (q[0] == 0) begin
          ref_mem[la] = ld;
          log_req = 1'b0;
        end else begin
          if (swe) ref_mem[sa] = sd;
          else check("rd_data", 32'(spi_rdata), 32'(ref_rd(sa)));
          spi_req = 1'b0;
        end
        last_g = q[0];
        void'(q.pop_front());
        due = t + 3 + int'(S);
      end
    end
    if (q.size() > 0) check("done_timeout", 32'(q.size()), 32'd0);
    log_req = 1'b0; spi_req = 1'b0;
    check("cen_cycles", 32'(cen_lo), 32'((2 + S) * n));
    check("wen_cycles", 32'(wen_lo), 32'(S * n_wr));
    check("oen_cycles", 32'(oen_lo), 32'(S * n_rd));
    check("oe_cycles", 32'(oe_hi), 32'((2 + S) * n_wr));
    if (n_rd == 0) check("rdata_hold", 32'(spi_rdata), 32'(rd_before));
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'({log_done, spi_done}), 32'd0);
    check("idle_strobes", 32'({sram_cen, sram_oen, sram_wen, sram_dq_oe}), 32'hE);
  endtask

  initial begin
    int n, last_t;
    bit lr, sr;
    rst = 1'b1;
    log_req = 0; log_addr = '0; log_wdata = '0;
    spi_req = 0; spi_we = 0; spi_addr = '0; spi_wdata = '0;
    log_req1 = 0; log_addr1 = '0; log_wdata1 = '0;
    spi_req1 = 0; spi_we1 = 0; spi_addr1 = '0; spi_wdata1 = '0;
    last_g = 1;
    tick();
    tick();
    check("rst_strobes", 32'({sram_cen, sram_oen, sram_wen, sram_dq_oe}), 32'hE);
    check("rst_done", 32'({log_done, spi_done}), 32'd0);
    check("rst_rdata", 32'(spi_rdata), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Both requesters held continuously: service must alternate, logger first.
    log_req = 1; log_addr = AW'(17'h00100); log_wdata = 8'h11;
    spi_req = 1; spi_we = 0; spi_addr = AW'(17'h00101);
    n = 0; last_t = 0;
    for (int t = 1; t <= 60 && n < 8; t++) begin
      tick();
      if (log_done || spi_done) begin
        check("alt_owner", 32'({log_done, spi_done}), (n % 2 == 0) ? 32'd2 : 32'd1);
        check("alt_gap", 32'(t - last_t), (n == 0) ? 32'(2 + S) : 32'(3 + S));
        last_t = t;
        n++;
        if (n == 8) begin log_req = 0; spi_req = 0; end
      end
    end
    check("alt_count", 32'(n), 32'd8);
    log_req = 0; spi_req = 0;
    last_g = 1;
    tick();

    run_round(1'b1, 1'b0, 1'b0, AW'(17'h1ABCD), 8'h5A, '0, '0);
    run_round(1'b0, 1'b1, 1'b0, '0, '0, AW'(17'h00010), '0);
    check("rd_c3", 32'(spi_rdata), 32'hC3);

    for (int r = 0; r < 24; r++) begin
      lr = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      if (!lr && !sr) lr = 1'b1;
      run_round(lr, sr, 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 31)), DW'($urandom),
                AW'($urandom_range(0, 31)), DW'($urandom));
    end

    // Reset in the first STROBE cycle of a logger write aborts it silently.
    log_req = 1; log_addr = AW'(17'h1F000); log_wdata = 8'hA5;
    tick();
    tick();
    check("abort_in_strobe", 32'(sram_wen), 32'd0);
    rst = 1'b1;
    log_req = 0;
    tick();
    check("abort_strobes", 32'({sram_cen, sram_oen, sram_wen, sram_dq_oe}), 32'hE);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(log_done), 32'd0);
    check("abort_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;
    last_g = 1;
    for (int t = 0; t < 6; t++) begin
      tick();
      check("abort_no_done", 32'({log_done, spi_done}), 32'd0);
    end

    // Single-cycle strobe build: SPI write completes three cycles after grant.
    spi_req1 = 1; spi_we1 = 1; spi_addr1 = '0; spi_wdata1 = 8'hFF;
    cen_lo = 0; wen_lo = 0; oe_hi = 0; n = 0;
    for (int t = 1; t <= 10 && n == 0; t++) begin
      tick();
      if (!sram_cen1) cen_lo++;
      if (!sram_dq_oe1) ; else oe_hi++;
      if (!sram_wen1) begin
        wen_lo++;
        check("s1_wr_addr", 32'(sram_addr1), 32'd0);
        check("s1_wr_data", 32'(sram_dq_o1), 32'hFF);
      end
      if (spi_done1) begin
        check("s1_latency", 32'(t), 32'(2 + S1));
        n = 1;
        spi_req1 = 0;
      end
    end
    check("s1_done_seen", 32'(n), 32'd1);
    check("s1_wen_cycles", 32'(wen_lo), 32'(S1));
    check("s1_cen_cycles", 32'(cen_lo), 32'(2 + S1));
    check("s1_oe_cycles", 32'(oe_hi), 32'(2 + S1));
    tick();
    check("s1_idle_busy", 32'(busy1), 32'd0);
    check("s1_rdata", 32'(spi_rdata1), 32'd0);
    check("s1_idle_done", 32'(spi_done1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
